// File: rtl/load_store_unit.sv
// Load/store unit between a single-cycle core and a word-addressed data memory.
// Handles byte/half/word loads with extension and sub-word stores via read-modify-write.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t      state_r;
    logic        ready_r;
    logic        resp_valid_r;
    logic [31:0] resp_rdata_r;
    logic        resp_err_r;
    logic [31:0] addr_r;
    logic [2:0]  funct3_r;
    logic        we_r;
    logic [31:0] wdata_r;
    logic [31:0] mem_wd_r;

    // Misalignment and illegal-encoding detection; such requests never reach memory.
    function automatic logic is_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic e;
        e = 1'b1;
        case (f3)
            3'b000:  e = 1'b0;
            3'b001:  e = off[0];
            3'b010:  e = (off != 2'b00);
            3'b100:  e = we;
            3'b101:  e = we | off[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0] byte_s;
        logic [31:0] half_s;
        logic [31:0] res;
        byte_s = word >> {off, 3'b000};
        half_s = word >> {off[1], 4'b0000};
        case (f3)
            3'b000:  res = {{24{byte_s[7]}}, byte_s[7:0]};
            3'b001:  res = {{16{half_s[15]}}, half_s[15:0]};
            3'b010:  res = word;
            3'b100:  res = {24'd0, byte_s[7:0]};
            3'b101:  res = {16'd0, half_s[15:0]};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Replace the addressed little-endian lane of the old word with the store data.
    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] old, input logic [31:0] wdata);
        logic [31:0] mask_s;
        logic [31:0] data_s;
        case (f3)
            3'b000: begin
                mask_s = 32'h0000_00FF << {off, 3'b000};
                data_s = {24'd0, wdata[7:0]} << {off, 3'b000};
            end
            3'b001: begin
                mask_s = 32'h0000_FFFF << {off[1], 4'b0000};
                data_s = {16'd0, wdata[15:0]} << {off[1], 4'b0000};
            end
            default: begin
                mask_s = 32'hFFFF_FFFF;
                data_s = wdata;
            end
        endcase
        return (old & ~mask_s) | (data_s & mask_s);
    endfunction

    // Request FSM with registered response and write-data outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
            addr_r       <= 32'd0;
            funct3_r     <= 3'd0;
            we_r         <= 1'b0;
            wdata_r      <= 32'd0;
            mem_wd_r     <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= 32'd0;
                    resp_err_r   <= 1'b0;
                    if (req_valid && ready_r) begin
                        addr_r   <= req_addr;
                        funct3_r <= req_funct3;
                        we_r     <= req_we;
                        wdata_r  <= req_wdata;
                        ready_r  <= 1'b0;
                        if (is_err(req_we, req_funct3, req_addr[1:0])) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                        end else if (!req_we) begin
                            state_r <= LOAD;
                        end else if (req_funct3 == 3'b010) begin
                            state_r  <= WRITE;
                            mem_wd_r <= req_wdata;
                        end else begin
                            state_r <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    resp_rdata_r <= load_extend(funct3_r, addr_r[1:0], mem_RD);
                    resp_valid_r <= 1'b1;
                    state_r      <= RESP;
                end
                RMW_RD: begin
                    mem_wd_r <= store_merge(funct3_r, addr_r[1:0], mem_RD, wdata_r);
                    state_r  <= WRITE;
                end
                WRITE: begin
                    resp_valid_r <= 1'b1;
                    state_r      <= RESP;
                end
                RESP: begin
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= 32'd0;
                    resp_err_r   <= 1'b0;
                    ready_r      <= 1'b1;
                    state_r      <= IDLE;
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= 32'd0;
                    resp_err_r   <= 1'b0;
                    ready_r      <= 1'b1;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    // Gating the strobe with rst_n lets a reset in the WRITE cycle cancel the write.
    assign mem_WE     = (state_r == WRITE) && rst_n;
    assign mem_A      = {addr_r[31:2], 2'b00};
    assign mem_WD     = mem_wd_r;
    assign req_ready  = ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

    // we_r is kept for observability of the latched request.
    logic unused_s;
    assign unused_s = we_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed test-plan cases, reset abort,
// then randomized back-to-back traffic against a behavioural memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    // Data memory seen by the DUT, and the reference image kept by the model.
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic        sync_mem;

    assign mem_RD = mem[mem_A[9:2]];

    always @(posedge clk) begin
        if (sync_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (mem_WE) begin
            mem[mem_A[9:2]] <= mem_WD;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] at;
    } resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] at;
    } wr_t;

    resp_t rq[$];
    wr_t   wq[$];
    int    checks = 0;
    int    errors = 0;
    logic  mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: computes the response and memory effect from the ISA rules.
    task automatic expect_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic use_exp,
                              input logic [31:0] exp_rdata);
        int unsigned off, idx, lat;
        logic        err;
        logic [31:0] word, val, b, h, mask, nw;
        resp_t       r;
        wr_t         w;
        off  = addr % 4;
        idx  = (addr / 4) % 256;
        word = ref_mem[idx];
        b    = (word >> (8 * off)) & 32'hFF;
        h    = (word >> (16 * (off / 2))) & 32'hFFFF;
        val  = 32'd0;
        nw   = word;
        err  = 1'b1;
        if (!we) begin
            case (f3)
                3'd0: begin err = 1'b0; val = (b >= 32'd128) ? (b | 32'hFFFFFF00) : b; end
                3'd1: begin err = (off % 2 != 0); val = (h >= 32'd32768) ? (h | 32'hFFFF0000) : h; end
                3'd2: begin err = (off != 0); val = word; end
                3'd4: begin err = 1'b0; val = b; end
                3'd5: begin err = (off % 2 != 0); val = h; end
                default: err = 1'b1;
            endcase
        end else begin
            case (f3)
                3'd0: begin err = 1'b0; mask = 32'hFF << (8 * off);
                            nw = (word & ~mask) | ((wdata & 32'hFF) << (8 * off)); end
                3'd1: begin err = (off % 2 != 0); mask = 32'hFFFF << (16 * (off / 2));
                            nw = (word & ~mask) | ((wdata & 32'hFFFF) << (16 * (off / 2))); end
                3'd2: begin err = (off != 0); nw = wdata; end
                default: err = 1'b1;
            endcase
        end
        if (err) begin
            val = 32'd0;
            lat = 1;
        end else if (!we || f3 == 3'd2) begin
            lat = 2;
        end else begin
            lat = 3;
        end
        if (we) val = 32'd0;
        if (use_exp) val = exp_rdata;
        if (we && !err) begin
            ref_mem[idx] = nw;
            w.addr = addr & 32'hFFFF_FFFC;
            w.data = nw;
            w.at   = cyc + lat - 1;
            wq.push_back(w);
        end
        r.rdata = val;
        r.err   = err;
        r.at    = cyc + lat;
        rq.push_back(r);
    endtask

    // Issue one request as soon as the DUT is ready; bounded wait.
    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic use_exp, input logic [31:0] exp_rdata);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("ready_timeout", {31'd0, req_ready}, 32'd1);
        end else begin
            req_valid  = 1'b1;
            req_we     = we;
            req_funct3 = f3;
            req_addr   = addr;
            req_wdata  = wdata;
            expect_req(we, f3, addr, wdata, use_exp, exp_rdata);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || wq.size() != 0 || !req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_resp_q", rq.size(), 32'd0);
        check("drain_wr_q", wq.size(), 32'd0);
    endtask

    resp_t mon_r;
    wr_t   mon_w;

    // Monitor: every response and every memory write must match the next expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (resp_valid) begin
                if (rq.size() == 0) begin
                    check("unexpected_resp_valid", 32'd1, 32'd0);
                end else begin
                    mon_r = rq.pop_front();
                    check("resp_rdata", resp_rdata, mon_r.rdata);
                    check("resp_err", {31'd0, resp_err}, {31'd0, mon_r.err});
                    check("resp_cycle", cyc, mon_r.at);
                end
            end else begin
                check("idle_rdata", resp_rdata, 32'd0);
                check("idle_err", {31'd0, resp_err}, 32'd0);
            end
            if (mem_WE) begin
                if (wq.size() == 0) begin
                    check("unexpected_mem_WE", 32'd1, 32'd0);
                end else begin
                    mon_w = wq.pop_front();
                    check("mem_A", mem_A, mon_w.addr);
                    check("mem_WD", mem_WD, mon_w.data);
                    check("write_cycle", cyc, mon_w.at);
                end
            end
        end
    end

    int mism;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        ref_mem[0] = 32'hFACEFACE;
        ref_mem[1] = 32'h00000002;
        sync_mem   = 1'b1;
        repeat (3) @(posedge clk);
        #1 sync_mem = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_mem_WE", {31'd0, mem_WE}, 32'd0);
        check("rst_mem_WD", mem_WD, 32'd0);
        check("rst_mem_A", mem_A, 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Directed loads on word 0 = FACEFACE.
        drive_req(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 32'hFFFFFFCE);
        drive_req(1'b0, 3'b100, 32'h1, 32'h0, 1'b1, 32'h000000FA);
        drive_req(1'b0, 3'b001, 32'h2, 32'h0, 1'b1, 32'hFFFFFACE);
        drive_req(1'b0, 3'b101, 32'h0, 32'h0, 1'b1, 32'h0000FACE);
        drive_req(1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 32'hFACEFACE);
        // sb then lw of the merged word.
        drive_req(1'b1, 3'b000, 32'h5, 32'h0000AB12, 1'b0, 32'h0);
        drive_req(1'b0, 3'b010, 32'h4, 32'h0, 1'b1, 32'h00001202);
        wait_drain();
        ref_mem[1] = 32'h00000002;
        @(negedge clk) sync_mem = 1'b1;
        @(posedge clk) #1 sync_mem = 1'b0;
        drive_req(1'b1, 3'b001, 32'h6, 32'h0000BEEF, 1'b0, 32'h0);
        drive_req(1'b0, 3'b010, 32'h4, 32'h0, 1'b1, 32'hBEEF0002);
        drive_req(1'b1, 3'b010, 32'hFC, 32'h12345678, 1'b0, 32'h0);
        drive_req(1'b0, 3'b010, 32'hFC, 32'h0, 1'b1, 32'h12345678);
        // Error cases.
        drive_req(1'b1, 3'b001, 32'h3, 32'hFFFF, 1'b0, 32'h0);
        drive_req(1'b0, 3'b010, 32'h2, 32'h0, 1'b0, 32'h0);
        drive_req(1'b0, 3'b011, 32'h0, 32'h0, 1'b0, 32'h0);
        wait_drain();

        // Reset during the WRITE cycle of sb @0: no write, no response.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h55;
        @(posedge clk) #1 req_valid = 1'b0;
        @(posedge clk) #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_mem_WE", {31'd0, mem_WE}, 32'd0);
        @(posedge clk) #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("abort_mem_WD", mem_WD, 32'd0);
        check("abort_word0", mem[0], 32'hFACEFACE);
        repeat (4) @(negedge clk);

        // Random traffic with req_valid mostly held high.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            req_valid  = ($urandom_range(0, 9) != 0);
            req_we     = $urandom_range(0, 1);
            req_funct3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                     : (req_we ? 3'($urandom_range(0, 2))
                                                               : 3'($urandom_range(0, 5)));
            req_addr   = $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 0) req_addr = req_addr & 32'hFFFF_FFFC;
            req_wdata  = $urandom;
            if (req_valid && req_ready)
                expect_req(req_we, req_funct3, req_addr, req_wdata, 1'b0, 32'h0);
        end
        @(negedge clk) req_valid = 1'b0;
        wait_drain();

        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        check("final_memory_mismatch_words", mism, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side load/store unit sitting between the single-cycle core's memory stage and the word-addressed data memory. The data memory has an asynchronous word read and a synchronous word-only write. This block accepts one byte, halfword or word request at a time. It performs sign or zero extension for loads and read-modify-write merging for sub-word stores, and returns one response per request. Misaligned accesses and illegal funct3 codes are flagged and never touch memory.

## Interface
- Parameters: none.
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  1  core presents a request.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready at a posedge.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3. Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores: 000 sb, 001 sh, 010 sw.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte/half is used for sb/sh.
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_rdata  out  32  extended load data. Valid with resp_valid for loads; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; 1 = misaligned or illegal funct3.
- mem_A  out  32  word address {addr_q[31:2],2'b00}.
- mem_WD  out  32  write data.
- mem_WE  out  1  word write enable.
- mem_RD  in  32  combinational read data for mem_A.

## Operation
- Request registers latched on accept: addr_q, funct3_q, we_q, wdata_q.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- From IDLE on accept:
  - error → RESP with err=1;
  - load → LOAD;
  - sw → WRITE;
  - sb/sh → RMW_RD.
- LOAD: sample mem_RD, extract and extend it into resp_rdata, → RESP.
- RMW_RD: capture mem_RD into merge register, replace the addressed lane with wdata_q, → WRITE.
- WRITE: mem_WE=1, mem_WD = merged word (sb/sh) or wdata_q (sw), → RESP.
- RESP: resp_valid=1 for one cycle, → IDLE.
- Lanes are little-endian:
  - byte k = addr[1:0] selects word[8k+7:8k];
  - half h = addr[1] selects word[16h+15:16h].
- Extension:
  - lb/lh sign-extend from bit 7/15;
  - lbu/lhu zero-extend;
  - lw passes the word through.
- Errors:
  - lh/lhu/sh with addr[0]=1;
  - lw/sw with addr[1:0]≠0;
  - load funct3 ∈ {011,110,111};
  - store funct3 ∉ {000,001,010}.
- An error produces no memory access: mem_WE stays 0 throughout.
- mem_WE = (state==WRITE) && rst_n, so a reset asserted in the WRITE cycle suppresses the write.
- mem_A is driven from addr_q in every non-IDLE state. In IDLE it holds its last value and is don't-care.

## Timing
- Reset (rst_n=0 at posedge): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_WE=0, mem_WD=0, all request registers 0.
- Reset mid-operation aborts the request with no response and no write. The bench must not see resp_valid for it.
- Latency from the accept edge T (resp_valid high in the cycle after the listed edge):
  - loads: LOAD at T+1, RESP at T+2;
  - sw: WRITE at T+1, RESP at T+2;
  - sb/sh: RMW_RD at T+1, WRITE at T+2, RESP at T+3;
  - error: RESP at T+1.
- req_ready=0 in all non-IDLE states. Requests presented then are ignored, not queued.
- RESP returns to IDLE, so back-to-back requests have a minimum issue interval of 3 cycles (loads/sw) or 4 cycles (sb/sh).
- resp_rdata and resp_err are registered and hold their values only during the RESP cycle; they are 0 otherwise.
- Writes land in memory at the posedge ending the WRITE cycle. A subsequent load of the same word observes the new data.
- req_* inputs are sampled only at the accept edge. Changes afterward have no effect.

## Test plan
- Word 0 = 0xFACEFACE. Expected load results:
  - lb @0x0 → resp_rdata 0xFFFFFFCE;
  - lbu @0x1 → 0x000000FA;
  - lh @0x2 → 0xFFFFFACE;
  - lhu @0x0 → 0x0000FACE;
  - lw @0x0 → 0xFACEFACE.
  - Each response has err=0 and arrives 2 cycles after accept.
- Sub-word store, word 1 = 0x00000002:
  - sb wdata 0xAB12 @0x5 → single mem_WE pulse at T+2 with mem_WD 0x00001202;
  - lw @0x4 then returns 0x00001202.
- sh wdata 0xBEEF @0x6 on word 1 = 0x00000002 → word becomes 0xBEEF0002. sw 0x12345678 @0xFC → word 63 = 0x12345678, with mem_WE at T+1.
- Errors, each giving resp_valid with err=1 at T+1 and mem_WE never asserted:
  - sh @0x3;
  - lw @0x2;
  - load funct3=011.
- Assert rst_n=0 during the WRITE cycle of sb @0x0:
  - word 0 stays 0xFACEFACE;
  - no resp_valid;
  - req_ready=1 after reset.
- Hold req_valid high continuously with alternating load/store requests:
  - each is accepted only when req_ready=1;
  - exactly one resp_valid per accepted request;
  - no overlap.
